// File: rtl/ps2_host_tx_if.sv
// Host-side request/status bundle for the PS/2 host transmitter.
// The master issues bytes; the slave (ps2_host_tx) reports progress and outcome.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_ok, timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_ok, timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send, then
// shifts a byte out on device clock falls and checks the device acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2600,
    parameter int TIMEOUT_CYCLES = 400000,
    parameter int CNT_W          = 19
) (
    input  logic         clk,
    input  logic         RSTB,
    ps2_host_tx_if.slave host,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        XFER,
        ACK,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_sat;
    logic [3:0]       idx, idx_nx;
    logic [9:0]       frame, frame_nx;
    logic             ack_ok_r, ack_nx;
    logic             timeout_r, timeout_nx;
    logic             clk_oe_nx, data_oe_nx;
    logic             clk_s1, clk_s2, clk_s3;
    logic             data_s1, data_s2;
    logic             fall;

    // Lines idle high, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            fall    <= 1'b0;
        end else begin
            clk_s1  <= ps2_clk_i;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data_i;
            data_s2 <= data_s1;
            fall    <= clk_s3 & ~clk_s2;
        end
    end

    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            frame       <= '0;
            ack_ok_r    <= 1'b0;
            timeout_r   <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            frame       <= frame_nx;
            ack_ok_r    <= ack_nx;
            timeout_r   <= timeout_nx;
            ps2_clk_oe  <= clk_oe_nx;
            ps2_data_oe <= data_oe_nx;
        end
    end

    assign cnt_sat = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx;
        frame_nx   = frame;
        ack_nx     = ack_ok_r;
        timeout_nx = timeout_r;
        clk_oe_nx  = 1'b0;
        data_oe_nx = ps2_data_oe;

        case (state)
            IDLE: begin
                data_oe_nx = 1'b0;
                if (host.tx_valid) begin
                    // Frame holds d0..d7, odd parity, stop; start is driven by RTS.
                    frame_nx   = {1'b1, ~^host.tx_data, host.tx_data};
                    ack_nx     = 1'b0;
                    timeout_nx = 1'b0;
                    cnt_nx     = '0;
                    idx_nx     = '0;
                    clk_oe_nx  = 1'b1;
                    state_nx   = INHIBIT;
                end
            end

            INHIBIT: begin
                data_oe_nx = 1'b0;
                if (cnt >= INHIBIT_LAST) begin
                    cnt_nx     = '0;
                    data_oe_nx = 1'b1;
                    state_nx   = RTS;
                end else begin
                    cnt_nx    = cnt_sat;
                    clk_oe_nx = 1'b1;
                end
            end

            RTS, XFER, ACK: begin
                if (fall) begin
                    cnt_nx = '0;
                    if (state == RTS) begin
                        idx_nx   = '0;
                        state_nx = XFER;
                    end else if (state == XFER) begin
                        data_oe_nx = ~frame[idx];
                        idx_nx     = idx + 4'd1;
                        if (idx == 4'd9) state_nx = ACK;
                    end else begin
                        data_oe_nx = 1'b0;
                        ack_nx     = ~data_s2;
                        state_nx   = DONE;
                    end
                end else if (cnt >= TIMEOUT_LAST) begin
                    data_oe_nx = 1'b0;
                    timeout_nx = 1'b1;
                    ack_nx     = 1'b0;
                    state_nx   = DONE;
                end else begin
                    cnt_nx = cnt_sat;
                    if (state == ACK) data_oe_nx = 1'b0;
                end
            end

            DONE: begin
                data_oe_nx = 1'b0;
                state_nx   = IDLE;
            end

            default: begin
                data_oe_nx = 1'b0;
                state_nx   = IDLE;
            end
        endcase
    end

    assign host.tx_ready = (state == IDLE);
    assign host.busy     = (state != IDLE);
    assign host.done     = (state == DONE);
    assign host.ack_ok   = ack_ok_r;
    assign host.timeout  = timeout_r;

endmodule
